// File: rtl/uart_pkg.sv
// Shared types and constants for the second-generation UART receiver with
// its receive FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP1     = 3'd4,
        ST_STOP2     = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } rx_state_e;

    localparam int MIN_DIV = 2;

    // FIFO entry layout: {perr, ferr, data[DATA_BITS-1:0]}
    function automatic int ferr_bit(input int data_bits);
        return data_bits;
    endfunction

    function automatic int perr_bit(input int data_bits);
        return data_bits + 1;
    endfunction

endpackage

// File: rtl/uart_rx_sfifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible on rdata
// whenever the FIFO is not empty and reads as zero when it is.
module uart_rx_sfifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // The extra pointer bit separates full (MSBs differ) from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers are, and
    // rdata is masked while empty so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receiver: 2-flop input synchroniser, frame FSM (5-9 data bits,
// optional parity, 1/2 stop bits, glitch and break handling) feeding a FWFT FIFO.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CNT_W-1:0]              clk_div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    input  logic [$clog2(FIFO_DEPTH):0]   irq_level,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          break_det,
    output logic                          irq,
    output logic                          busy
);

    localparam int                WORD_W   = DATA_BITS + 2;
    localparam int                LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int                FERR_BIT = ferr_bit(DATA_BITS);
    localparam int                PERR_BIT = perr_bit(DATA_BITS);
    localparam logic [3:0]        LAST_IDX = 4'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DIV_MIN  = CNT_W'(MIN_DIV);

    rx_state_e            state_q, state_d;
    logic                 rx_meta_q, rx_meta_d, rxs_q, rxs_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, div_q, div_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d, perr_q, perr_d;
    logic                 par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic                 overrun_q, overrun_d, irq_q, irq_d;
    logic                 break_q, break_d, busy_q, busy_d;

    logic                 half_hit, bit_hit, push;
    logic [WORD_W-1:0]    push_word, fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [LVL_W-1:0]     fifo_count, eff_level;

    assign half_hit  = (cnt_q == (div_q >> 1) - CNT_ONE);
    assign bit_hit   = (cnt_q == div_q - CNT_ONE);
    assign fifo_pop  = rd_en && !fifo_empty;
    assign eff_level = (irq_level == '0) ? LVL_W'(1) : irq_level;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        rx_meta_d = rx;
        rxs_d     = rx_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        push      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Configuration is tracked only here and frozen for the frame.
                div_d     = (clk_div < DIV_MIN) ? DIV_MIN : clk_div;
                par_en_d  = parity_en;
                par_odd_d = parity_odd;
                stop2_d   = stop2;
                if (!rxs_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (half_hit) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = '0;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                    state_d = rxs_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_hit) begin
                    cnt_d   = '0;
                    // LSB-first: after DATA_BITS shifts bit 0 sits at the bottom.
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (bit_hit) begin
                    cnt_d   = '0;
                    perr_d  = (^shift_q) ^ rxs_q ^ par_odd_q;
                    state_d = ST_STOP1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP1: begin
                if (bit_hit) begin
                    cnt_d  = '0;
                    ferr_d = !rxs_q;
                    if (stop2_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        push    = 1'b1;
                        state_d = rxs_q ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP2: begin
                if (bit_hit) begin
                    cnt_d   = '0;
                    ferr_d  = ferr_q | !rxs_q;
                    push    = 1'b1;
                    state_d = rxs_q ? ST_IDLE : ST_WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line must yield a single frame, not a stream.
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        push_word = {perr_d, ferr_d, shift_q};
        break_d   = push && (shift_q == '0) && ferr_d && !perr_d;

        if (push && fifo_full && !fifo_pop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        irq_d  = (fifo_count >= eff_level) | overrun_q;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            cnt_q     <= '0;
            div_q     <= DIV_MIN;
            idx_q     <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
            break_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rxs_q     <= rxs_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
            break_q   <= break_d;
            busy_q    <= busy_d;
        end
    end

    uart_rx_sfifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_word),
        .pop   (rd_en),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rd_data       = fifo_rdata[DATA_BITS-1:0];
    assign rd_frame_err  = fifo_rdata[FERR_BIT];
    assign rd_parity_err = fifo_rdata[PERR_BIT];
    assign rx_empty      = fifo_empty;
    assign rx_count      = fifo_count;
    assign overrun       = overrun_q;
    assign break_det     = break_q;
    assign irq           = irq_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: an 8-bit/depth-4 instance and a 7-bit instance
// share one serial line; results are checked against a queue-based model.
`timescale 1ns/1ps
module tb_uart_rx_fifo_ctrl;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, parity_en, parity_odd, stop2, rx, rd_en, overrun_clr;
    logic [31:0]   clk_div;
    logic [LW-1:0] irq_level;

    logic [7:0]    a_data;
    logic          a_ferr, a_perr, a_empty, a_ovr, a_brk, a_irq, a_busy;
    logic [LW-1:0] a_count;
    logic [6:0]    b_data;
    logic          b_ferr, b_perr, b_empty, b_ovr, b_brk, b_irq, b_busy;
    logic [LW-1:0] b_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int brk_cnt      = 0;
    int last_fall    = 0;
    logic busy_prev  = 1'b0;

    logic [9:0] model_q[$];   // {perr, ferr, data}
    bit         model_ovr;

    always #5 clk = ~clk;

    uart_rx_fifo_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .clk_div(clk_div), .parity_en(parity_en),
        .parity_odd(parity_odd), .stop2(stop2), .irq_level(irq_level), .rx(rx),
        .rd_en(rd_en), .rd_data(a_data), .rd_frame_err(a_ferr), .rd_parity_err(a_perr),
        .rx_empty(a_empty), .rx_count(a_count), .overrun(a_ovr), .overrun_clr(overrun_clr),
        .break_det(a_brk), .irq(a_irq), .busy(a_busy)
    );

    uart_rx_fifo_ctrl #(.DATA_BITS(7), .FIFO_DEPTH(DEPTH), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .clk_div(clk_div), .parity_en(parity_en),
        .parity_odd(parity_odd), .stop2(stop2), .irq_level(irq_level), .rx(rx),
        .rd_en(rd_en), .rd_data(b_data), .rd_frame_err(b_ferr), .rd_parity_err(b_perr),
        .rx_empty(b_empty), .rx_count(b_count), .overrun(b_ovr), .overrun_clr(overrun_clr),
        .break_det(b_brk), .irq(b_irq), .busy(b_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_brk === 1'b1) brk_cnt = brk_cnt + 1;
        if (busy_prev && a_busy === 1'b0) last_fall = cyc;
        busy_prev = (a_busy === 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [8:0] data, input int nbits, input bit pbit,
                        input bit s1, input bit s2);
        int div;
        div = int'(clk_div);
        hold(1'b0, div);
        for (int i = 0; i < nbits; i++) hold(data[i], div);
        if (parity_en) hold(pbit, div);
        hold(s1, div);
        if (stop2) hold(s2, div);
        rx = 1'b1;
    endtask

    // Expected FIFO word for an 8-bit frame under the current configuration.
    function automatic logic [9:0] mk_word(input logic [7:0] data, input bit pbit,
                                           input bit s1, input bit s2);
        int  ones;
        bit  good_pbit, perr, ferr;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(data[i]);
        good_pbit = parity_odd ? (ones % 2 == 0) : (ones % 2 == 1);
        perr = parity_en && (pbit != good_pbit);
        ferr = !s1 || (stop2 && !s2);
        return {perr, ferr, data};
    endfunction

    task automatic model_push(input logic [9:0] w);
        if (model_q.size() < DEPTH) model_q.push_back(w);
        else model_ovr = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] w;
        w = (model_q.size() > 0) ? model_q.pop_front() : 10'h0;
        check({tag, "_data"}, 32'(a_data), 32'(w[7:0]));
        check({tag, "_ferr"}, 32'(a_ferr), 32'(w[8]));
        check({tag, "_perr"}, 32'(a_perr), 32'(w[9]));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        model_ovr = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_empty"}, 32'(a_empty), 32'd1);
        check({tag, "_count"}, 32'(a_count), 32'd0);
        check({tag, "_rd"},    32'({a_perr, a_ferr, a_data}), 32'd0);
        check({tag, "_ovr"},   32'(a_ovr), 32'd0);
        check({tag, "_brk"},   32'(a_brk), 32'd0);
        check({tag, "_irq"},   32'(a_irq), 32'd0);
        check({tag, "_busy"},  32'(a_busy), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic [9:0] w6;
        int         s5, off, s6, nb, lvl;
        bit         seen, pb, s1, s2;

        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; overrun_clr = 1'b0;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        clk_div = 32'd16; irq_level = LW'(1);
        model_ovr = 1'b0;
        do_reset();

        // Reset state of both instances
        check_reset_a("rst_a");
        check("rst_b", 32'({b_empty, b_count, b_perr, b_ferr, b_data, b_ovr, b_brk, b_irq, b_busy}),
              32'({1'b1, LW'(0), 1'b0, 1'b0, 7'h0, 1'b0, 1'b0, 1'b0, 1'b0}));

        // Test 1: 8N1, two frames
        send(9'h055, 8, 1'b0, 1'b1, 1'b1); model_push(mk_word(8'h55, 1'b0, 1'b1, 1'b1));
        hold(1'b1, 32);
        send(9'h0A3, 8, 1'b0, 1'b1, 1'b1); model_push(mk_word(8'hA3, 1'b0, 1'b1, 1'b1));
        hold(1'b1, 32);
        check("t1_count", 32'(a_count), 32'd2);
        check("t1_irq", 32'(a_irq), 32'd1);
        pop_check("t1_w0");
        pop_check("t1_w1");
        check("t1_empty", 32'(a_empty), 32'd1);
        hold(1'b1, 2);
        check("t1_irq_low", 32'(a_irq), 32'd0);

        // Test 2: 7E2 on the 7-bit instance, good then bad parity
        do_reset();
        parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
        hold(1'b1, 4);
        send(9'h041, 7, 1'b0, 1'b1, 1'b1); hold(1'b1, 32);
        send(9'h041, 7, 1'b1, 1'b1, 1'b1); hold(1'b1, 32);
        check("t2_count", 32'(b_count), 32'd2);
        check("t2_w0", 32'({b_perr, b_ferr, b_data}), 32'({1'b0, 1'b0, 7'h41}));
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        check("t2_w1", 32'({b_perr, b_ferr, b_data}), 32'({1'b1, 1'b0, 7'h41}));
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        check("t2_empty", 32'(b_empty), 32'd1);

        // Test 3: break, line held low for 12 bit times
        do_reset();
        parity_en = 1'b0; stop2 = 1'b0; clk_div = 32'd16;
        hold(1'b1, 4);
        nb = brk_cnt;
        hold(1'b0, 12 * 16);
        check("t3_count_low", 32'(a_count), 32'd1);
        check("t3_busy_low", 32'(a_busy), 32'd1);
        hold(1'b1, 40);
        check("t3_count", 32'(a_count), 32'd1);
        check("t3_busy", 32'(a_busy), 32'd0);
        check("t3_brk_pulses", 32'(brk_cnt - nb), 32'd1);
        model_push(10'b01_0000_0000);
        pop_check("t3_w");

        // Test 4: 3-cycle glitch is rejected
        hold(1'b0, 3);
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_busy === 1'b1) seen = 1'b1;
            if (seen && a_busy === 1'b0) break;
        end
        check("t4_busy_seen", 32'(seen), 32'd1);
        check("t4_busy_drop", 32'(a_busy), 32'd0);
        hold(1'b1, 40);
        check("t4_count", 32'(a_count), 32'd0);

        // Test 5: overrun with 5 frames, then simultaneous pop and push
        do_reset();
        clk_div = 32'd12; irq_level = LW'(4);
        hold(1'b1, 4);
        s5 = 0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            if (i == 4) s5 = cyc;
            send({1'b0, d}, 8, 1'b0, 1'b1, 1'b1);
            model_push(mk_word(d, 1'b0, 1'b1, 1'b1));
            hold(1'b1, 24);
        end
        off = last_fall - s5;
        check("t5_count", 32'(a_count), 32'd4);
        check("t5_ovr", 32'(a_ovr), 32'(model_ovr));
        check("t5_irq", 32'(a_irq), 32'd1);
        d = 8'($urandom);
        w6 = mk_word(d, 1'b0, 1'b1, 1'b1);
        s6 = cyc;
        fork
            send({1'b0, d}, 8, 1'b0, 1'b1, 1'b1);
            begin
                while (cyc < s6 + off - 1) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        void'(model_q.pop_front());
        model_q.push_back(w6);
        hold(1'b1, 24);
        check("t5_full_popush", 32'(a_count), 32'd4);
        check("t5_ovr_held", 32'(a_ovr), 32'd1);
        overrun_clr = 1'b1; @(negedge clk); overrun_clr = 1'b0;
        check("t5_ovr_clr", 32'(a_ovr), 32'd0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("t5_w%0d", i));
        check("t5_empty", 32'(a_empty), 32'd1);
        hold(1'b1, 2);
        check("t5_irq_low", 32'(a_irq), 32'd0);

        // Test 6: reset during data bit 3
        irq_level = LW'(1); clk_div = 32'd16;
        send(9'h033, 8, 1'b0, 1'b1, 1'b1); hold(1'b1, 32);
        check("t6_pre_count", 32'(a_count), 32'd1);
        d = 8'h5A;
        hold(1'b0, 16);
        for (int i = 0; i < 3; i++) hold(d[i], 16);
        hold(d[3], 8);
        check("t6_busy_mid", 32'(a_busy), 32'd1);
        rst = 1'b1; @(negedge clk); rst = 1'b0; rx = 1'b1;
        model_q.delete(); model_ovr = 1'b0;
        check_reset_a("t6_rst");
        hold(1'b1, 40);
        check("t6_idle_count", 32'(a_count), 32'd0);
        send({1'b0, d}, 8, 1'b0, 1'b1, 1'b1); model_push(mk_word(d, 1'b0, 1'b1, 1'b1));
        hold(1'b1, 32);
        check("t6_count", 32'(a_count), 32'd1);
        pop_check("t6_w");

        // Randomised frames against the queue model
        for (int it = 0; it < 12; it++) begin
            nb  = int'($urandom_range(1, 3));
            lvl = int'($urandom_range(0, 4));
            irq_level = LW'(lvl);
            for (int f = 0; f < nb; f++) begin
                parity_en  = 1'($urandom);
                parity_odd = 1'($urandom);
                stop2      = 1'($urandom);
                clk_div    = 32'($urandom_range(8, 20));
                d  = 8'($urandom);
                s1 = ($urandom_range(0, 6) != 0);
                s2 = ($urandom_range(0, 6) != 0);
                pb = mk_word(d, 1'b0, 1'b1, 1'b1) == 10'(d) ? 1'b0 : 1'b1;
                if ($urandom_range(0, 3) == 0) pb = !pb;
                hold(1'b1, 4);
                send({1'b0, d}, 8, pb, s1, s2);
                model_push(mk_word(d, pb, s1, s2));
                hold(1'b1, 2 * int'(clk_div));
            end
            check($sformatf("rnd%0d_count", it), 32'(a_count), 32'(model_q.size()));
            check($sformatf("rnd%0d_irq", it), 32'(a_irq),
                  32'((model_q.size() >= ((lvl == 0) ? 1 : lvl)) || model_ovr));
            while (model_q.size() > 0) pop_check($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_empty", it), 32'(a_empty), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
